// File: rtl/swi_pkg.sv
// Shared types and constants for the switch debouncer.
// The optional input synchronizer is enabled with SWI_SYNC_EN.
package swi_pkg;

  typedef enum logic {
    DEB_IDLE  = 1'b0,
    DEB_COUNT = 1'b1
  } deb_state_t;

  localparam int                BOUNCE_W   = 8;
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = 8'hFF;
  localparam int                NBITS_SWI  = 8;

endpackage

// File: rtl/swi_debounce_bit.sv
// One-bit debouncer: optional 2-flop synchronizer (SWI_SYNC_EN), accept FSM,
// rise/fall pulse registers and a combinational abort flag for the current edge.
module swi_debounce_bit
  import swi_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic abort
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic sample;

`ifdef SWI_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

  assign sample = sync_reg[1];
`else
  assign sample = raw;
`endif

  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stable_reg, stable_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             accept;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_reg  <= DEB_IDLE;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = '0;
    stable_next = stable_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    abort       = 1'b0;
    accept      = 1'b0;

    unique case (state_reg)
      DEB_IDLE: begin
        if (sample != stable_reg) begin
          if (STABLE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_next = DEB_COUNT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      DEB_COUNT: begin
        if (sample == stable_reg) begin
          // Input fell back before the candidate matured: a bounce.
          abort      = 1'b1;
          state_next = DEB_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          accept     = 1'b1;
          state_next = DEB_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = DEB_IDLE;
      end
    endcase

    if (accept) begin
      stable_next = sample;
      rise_next   = sample;
      fall_next   = ~sample;
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/swi_debounce.sv
// Per-bit switch debouncer array with change pulses and a saturating bounce counter.
// Define SWI_SYNC_EN to place a two-flop synchronizer ahead of each bit's FSM.
module swi_debounce
  import swi_pkg::*;
#(
  parameter int NBITS         = NBITS_SWI,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [NBITS-1:0]    swi_raw,
  input  logic                bounce_clr,
  output logic [NBITS-1:0]    swi_stable,
  output logic [NBITS-1:0]    swi_rise,
  output logic [NBITS-1:0]    swi_fall,
  output logic                changed,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  logic [NBITS-1:0]    abort_vec;
  logic [BOUNCE_W-1:0] bounce_reg, bounce_next;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_bit
      swi_debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
      ) u_bit (
        .clk_2 (clk_2),
        .reset (reset),
        .raw   (swi_raw[gi]),
        .stable(swi_stable[gi]),
        .rise  (swi_rise[gi]),
        .fall  (swi_fall[gi]),
        .abort (abort_vec[gi])
      );
    end
  endgenerate

  // Counts edges with any abort, not the number of aborting bits.
  always_comb begin
    bounce_next = bounce_reg;
    if (bounce_clr) begin
      bounce_next = '0;
    end else if ((|abort_vec) && (bounce_reg != BOUNCE_MAX)) begin
      bounce_next = bounce_reg + BOUNCE_W'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      bounce_reg <= '0;
    end else begin
      bounce_reg <= bounce_next;
    end
  end

  assign changed    = (|swi_rise) | (|swi_fall);
  assign bounce_cnt = bounce_reg;

endmodule

// File: tb/tb_swi_debounce.sv
// Directed self-checking bench for swi_debounce (STABLE_CYCLES=4, NBITS=8).
module tb_swi_debounce;

  localparam int NBITS  = 8;
  localparam int STABLE = 4;
`ifdef SWI_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = STABLE + SYNC_D;

  logic             clk_2 = 1'b0;
  logic             reset;
  logic [NBITS-1:0] swi_raw;
  logic             bounce_clr;
  logic [NBITS-1:0] swi_stable, swi_rise, swi_fall;
  logic             changed;
  logic [7:0]       bounce_cnt;

  int checks = 0;
  int errors = 0;

  swi_debounce #(.NBITS(NBITS), .STABLE_CYCLES(STABLE)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .swi_raw   (swi_raw),
    .bounce_clr(bounce_clr),
    .swi_stable(swi_stable),
    .swi_rise  (swi_rise),
    .swi_fall  (swi_fall),
    .changed   (changed),
    .bounce_cnt(bounce_cnt)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] exp_stable, input logic [7:0] exp_bc);
    check({tag, ".stable"}, swi_stable, exp_stable);
    check({tag, ".rise"}, swi_rise, 8'h00);
    check({tag, ".fall"}, swi_fall, 8'h00);
    check({tag, ".changed"}, changed, 1'b0);
    check({tag, ".bounce"}, bounce_cnt, exp_bc);
  endtask

  // Glitch of 3 samples on mask, returning to base; waits until the abort edge.
  task automatic glitch(input logic [7:0] base, input logic [7:0] mask);
    swi_raw = base ^ mask;
    repeat (3) tick();
    swi_raw = base;
    repeat (SYNC_D + 1) tick();
  endtask

  initial begin
    reset      = 1'b1;
    swi_raw    = 8'h00;
    bounce_clr = 1'b0;
    repeat (3) tick();
    check_quiet("reset", 8'h00, 8'h00);
    reset = 1'b0;

    // 1: idle zeros
    for (int i = 0; i < 10; i++) tick();
    check_quiet("idle", 8'h00, 8'h00);

    // 2: accept 0x07 after LAT samples, single-cycle pulse
    swi_raw = 8'h07;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      check_quiet("rise_wait", 8'h00, 8'h00);
    end
    tick();
    check("rise.stable", swi_stable, 8'h07);
    check("rise.rise", swi_rise, 8'h07);
    check("rise.fall", swi_fall, 8'h00);
    check("rise.changed", changed, 1'b1);
    tick();
    check_quiet("rise_after", 8'h07, 8'h00);

    // 3: 3-cycle glitch on bit 3 is rejected and counted once
    swi_raw = 8'h0F;
    repeat (3) tick();
    check_quiet("glitch_hold", 8'h07, 8'h00);
    swi_raw = 8'h07;
    repeat (SYNC_D + 1) tick();
    check_quiet("glitch_abort", 8'h07, 8'h01);

    // two bits aborting on the same edge count as one bounce
    glitch(8'h07, 8'h30);
    check_quiet("glitch_multi", 8'h07, 8'h02);

    // 4: fall of 0x07
    swi_raw = 8'h00;
    for (int i = 0; i < LAT - 1; i++) tick();
    check_quiet("fall_wait", 8'h07, 8'h02);
    tick();
    check("fall.stable", swi_stable, 8'h00);
    check("fall.fall", swi_fall, 8'h07);
    check("fall.rise", swi_rise, 8'h00);
    check("fall.changed", changed, 1'b1);
    tick();
    check("fall_after.fall", swi_fall, 8'h00);
    check("fall_after.changed", changed, 1'b0);

    // 5: saturation then clear coincident with an abort
    for (int i = 0; i < 252; i++) glitch(8'h00, 8'h08);
    check("sat.254", bounce_cnt, 8'd254);
    glitch(8'h00, 8'h08);
    check("sat.255", bounce_cnt, 8'd255);
    for (int i = 0; i < 45; i++) glitch(8'h00, 8'h08);
    check_quiet("sat.hold", 8'h00, 8'hFF);
    swi_raw = 8'h08;
    repeat (3) tick();
    swi_raw = 8'h00;
    repeat (SYNC_D) tick();
    bounce_clr = 1'b1;
    tick();
    bounce_clr = 1'b0;
    check_quiet("clr_vs_abort", 8'h00, 8'h00);

    // 6: reset mid-count discards the candidate
    glitch(8'h00, 8'h01);
    check("pre_reset.bounce", bounce_cnt, 8'h01);
    swi_raw = 8'hFF;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("mid_reset", 8'h00, 8'h00);
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      check_quiet("post_reset_wait", 8'h00, 8'h00);
    end
    tick();
    check("post_reset.stable", swi_stable, 8'hFF);
    check("post_reset.rise", swi_rise, 8'hFF);
    check("post_reset.changed", changed, 1'b1);
    check("post_reset.bounce", bounce_cnt, 8'h00);
    tick();
    check("post_reset_after.rise", swi_rise, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/swi_debounce.md
# swi_debounce

Input conditioning stage between the board switches `SWI` and the combinational decoders that drive `SEG`/`LED`, such as the grade classifier and the reservoir level indicator. Each switch bit is debounced independently: a new level is accepted only after it has been sampled for `STABLE_CYCLES` consecutive cycles. The block also emits one-cycle rise and fall pulses and keeps a saturating count of rejected glitches. Downstream logic consumes `swi_stable` in place of raw `SWI`.

## Interface
- `NBITS`, 8, number of switch bits debounced.
- `STABLE_CYCLES`, 4, consecutive equal samples required to accept a new level; legal range 1..65535.
- `CNT_W`, `$clog2(STABLE_CYCLES+1)`, width of each per-bit counter.
- `clk_2` input 1: sole clock; all flops update on its rising edge.
- `reset` input 1: synchronous, active-high.
- `swi_raw` input NBITS: raw switch levels.
- `bounce_clr` input 1: synchronous clear of `bounce_cnt`.
- `swi_stable` output NBITS: debounced levels.
- `swi_rise` output NBITS: one-cycle pulse per bit on an accepted 0→1 change.
- `swi_fall` output NBITS: one-cycle pulse per bit on an accepted 1→0 change.
- `changed` output 1: OR of all `swi_rise` and `swi_fall` bits, in the same cycle.
- `bounce_cnt` output 8: saturating count of cycles in which at least one bit aborted a candidate.

## Operation
- Per-bit FSM with states `DEB_IDLE` and `DEB_COUNT`, plus counter `cnt`.
- **`DEB_IDLE`**
  - Sample equal to `swi_stable[i]`: remain in `DEB_IDLE` with `cnt=0`.
  - Sample differs:
    - If `STABLE_CYCLES==1`, accept immediately.
    - Otherwise, go to `DEB_COUNT` with `cnt=1`.
- **`DEB_COUNT`**
  - Sample differs and `cnt==STABLE_CYCLES-1`: accept, return to `DEB_IDLE` with `cnt=0`.
  - Sample differs, count not yet reached: `cnt++`.
  - Sample equals stable: abort, return to `DEB_IDLE` with `cnt=0`, and raise that bit's abort flag for this edge.
- **Accept:** `swi_stable[i]` takes the sampled value. `swi_rise[i]` or `swi_fall[i]` is asserted on the same edge and held for exactly one cycle.
- **`bounce_cnt`:** increments by 1 on an edge where any abort flag is set, regardless of how many bits aborted.
  - Saturates at 255.
  - `bounce_clr` wins over a simultaneous increment; the result is 0.
- Bits are fully independent. Simultaneous accepts on several bits produce several pulse bits in the same cycle and a single `changed` pulse.
- **Reset:** all FSMs go to `DEB_IDLE`, `cnt=0`, `swi_stable=0`, `swi_rise=0`, `swi_fall=0`, `changed=0`, `bounce_cnt=0`, and synchronizer flops are 0.
  - Asserting `reset` mid-count discards the candidate; it is not counted as a bounce.
  - After release, a level must again be held for a full `STABLE_CYCLES` samples.

## Timing
- Let `swi_raw` change before edge k and stay constant. With no synchronizer, `swi_stable`, the pulse, and `changed` update at edge k+STABLE_CYCLES-1. This is a latency of `STABLE_CYCLES` samples.
- Pulses last exactly one cycle and are never asserted in consecutive cycles for the same bit.
- Minimum spacing between accepts on one bit: `STABLE_CYCLES` cycles.
- A glitch shorter than `STABLE_CYCLES` samples never reaches `swi_stable`.
- `bounce_cnt` updates on the same edge as the abort.

## Configuration
- Macro: `SWI_SYNC_EN`.
- **Defined:** a two-flop synchronizer per bit sits in front of the FSM. Total latency is `STABLE_CYCLES+2` cycles.
- **Undefined:** `swi_raw` feeds the FSM directly, which is intended for simulation or already-synchronous sources. Latency is `STABLE_CYCLES`.
- The port list is identical in both cases.

## Structure
- Package `swi_pkg`:
  - enum `deb_state_t` {`DEB_IDLE`, `DEB_COUNT`}
  - `BOUNCE_W=8`
  - `BOUNCE_MAX=8'hFF`
  - default `NBITS_SWI=8`
- Sub-module `swi_debounce_bit` handles one bit. It contains the synchronizer (under the macro), the FSM, the counter, the pulse registers and the abort flag, and is instantiated `NBITS` times with a generate loop.
- The top level reduces the abort flags and owns `bounce_cnt`.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `NBITS=8`, macro off unless stated.

1. Reset, then `swi_raw=0x00` for 10 cycles → `swi_stable=0x00`, no pulses, `bounce_cnt=0`.
2. `swi_raw` goes 0x00→0x07 before edge k and is held → `swi_stable=0x07` at edge k+3, `swi_rise=0x07` and `changed=1` for exactly one cycle, then 0.
3. From 0x07, bit 3 high for 3 cycles then low → `swi_stable` stays 0x07, no pulses, `bounce_cnt` 0→1.
4. From 0x07, `swi_raw=0x00` held → `swi_fall=0x07` for one cycle at the 4th sample, `swi_stable=0x00`.
5. 300 three-cycle glitches → `bounce_cnt` holds at 255. Then `bounce_clr` coincident with an abort → `bounce_cnt=0`.
6. `swi_raw=0xFF`, `reset` pulsed after 2 samples → `swi_stable=0x00` and `bounce_cnt=0`. After release, `swi_stable=0xFF` only after 4 further samples. Repeating scenario 2 with `SWI_SYNC_EN` defined → update at edge k+5.
